// File: rtl/meta_dispatch_pkg.sv
// Shared RMT metadata definitions: field offsets inside the final-stage
// metadata word and the dispatcher state encoding.
package meta_dispatch_pkg;

    // Field offsets inside the metadata word
    localparam int DISCARD_BIT = 128;
    localparam int PORT_HI     = 31;
    localparam int PORT_LO     = 24;
    localparam int NTID_HI     = 255;
    localparam int NTID_LO     = 250;

    // NetFPGA metadata and destination port widths
    localparam int MD_W   = 128;
    localparam int PORT_W = PORT_HI - PORT_LO + 1;

    // Dispatcher states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // FIFO empty, output register empty
        ST_EVAL = 2'd1,   // head present, output register empty
        ST_HOLD = 2'd2    // output register holds a descriptor (out_valid)
    } disp_state_e;

    // A descriptor is dropped when flagged for discard or aimed at port 0
    function automatic logic is_drop(input logic discard, input logic [PORT_W-1:0] port);
        return discard || (port == '0);
    endfunction

endpackage

// File: rtl/meta_fifo.sv
// Synchronous FIFO with registered pointers and a combinational head read.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module meta_fifo #(
    parameter int  WIDTH = 129,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push;
    logic             pop;

    // A write into a full FIFO and a read from an empty FIFO are both ignored
    assign push = wr_en && !full;
    assign pop  = rd_en && !empty;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; wraps modulo 2*DEPTH through natural overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/meta_dispatch.sv
// Final-stage metadata dispatcher: buffers descriptors, discards drop entries,
// and presents forward entries on a valid/ready output with saturating
// drop and overflow counters.
module meta_dispatch #(
    parameter int META_LEN   = 256,
    parameter int COMP_LEN   = 100,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [META_LEN+COMP_LEN-1:0] comp_meta_data_in,
    input  logic                       comp_meta_data_valid_in,
    output logic [127:0]               out_md,
    output logic [7:0]                 out_port,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic [CNT_W-1:0]           ovf_cnt,
    output logic                       fifo_full
);
    import meta_dispatch_pkg::*;

    localparam int W  = META_LEN + COMP_LEN;
    localparam int FW = DISCARD_BIT + 1;      // discard flag plus NetFPGA metadata
    localparam int AW = $clog2(FIFO_DEPTH);

    disp_state_e      state;
    disp_state_e      state_nxt;
    logic [FW-1:0]    head;
    logic             fifo_empty;
    logic             fifo_full_w;
    logic [AW:0]      fifo_count;
    logic             push;
    logic             pop;
    logic             load;
    logic             drop_hit;
    logic             ovf_hit;
    logic             head_drop;
    logic [MD_W-1:0]  head_md;
    logic [PORT_W-1:0] head_port;
    logic             unused_upper;

    // Counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Compare instruction and next_table_id are not needed downstream
    assign unused_upper = ^comp_meta_data_in[W-1:FW];

    assign push    = comp_meta_data_valid_in && !fifo_full_w;
    assign ovf_hit = comp_meta_data_valid_in && fifo_full_w;

    assign head_md   = head[MD_W-1:0];
    assign head_port = head[PORT_HI:PORT_LO];
    assign head_drop = is_drop(head[DISCARD_BIT], head_port);

    meta_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (comp_meta_data_in[FW-1:0]),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .full    (fifo_full_w),
        .count   (fifo_count)
    );

    // Next state and per-cycle pop/load/drop decisions
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        drop_hit  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty || push) state_nxt = ST_EVAL;
            end
            ST_EVAL: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_drop) begin
                        drop_hit  = 1'b1;
                        state_nxt = ((fifo_count > (AW+1)'(1)) || push) ? ST_EVAL : ST_IDLE;
                    end else begin
                        load      = 1'b1;
                        state_nxt = ST_HOLD;
                    end
                end else begin
                    state_nxt = push ? ST_EVAL : ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (!fifo_empty && !head_drop) begin
                        // Back-to-back: reload while the current word transfers
                        pop  = 1'b1;
                        load = 1'b1;
                    end else begin
                        state_nxt = (!fifo_empty || push) ? ST_EVAL : ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Output register; held stable while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_md   <= '0;
            out_port <= '0;
        end else if (load) begin
            out_md   <= head_md;
            out_port <= head_port;
        end
    end

    // Saturating drop and overflow counters
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
            ovf_cnt  <= '0;
        end else begin
            if (drop_hit) drop_cnt <= sat_inc(drop_cnt);
            if (ovf_hit)  ovf_cnt  <= sat_inc(ovf_cnt);
        end
    end

    assign out_valid = (state == ST_HOLD);
    assign fifo_full = fifo_full_w;

endmodule

// File: tb/tb_meta_dispatch.sv
// Directed bench for meta_dispatch with hand-computed expectations.
module tb_meta_dispatch;

    localparam int W     = 356;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     comp_meta_data_in;
    logic             comp_meta_data_valid_in;
    logic [127:0]     out_md;
    logic [7:0]       out_port;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] ovf_cnt;
    logic             fifo_full;

    int n_cmp  = 0;
    int n_fail = 0;

    meta_dispatch #(
        .META_LEN   (256),
        .COMP_LEN   (100),
        .FIFO_DEPTH (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .comp_meta_data_in       (comp_meta_data_in),
        .comp_meta_data_valid_in (comp_meta_data_valid_in),
        .out_md                  (out_md),
        .out_port                (out_port),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .drop_cnt                (drop_cnt),
        .ovf_cnt                 (ovf_cnt),
        .fifo_full               (fifo_full)
    );

    always #5 clk = ~clk;

    // Builds a word with junk in the ignored upper fields
    function automatic logic [W-1:0] mk(input logic disc, input logic [7:0] port, input logic [31:0] seed);
        logic [383:0] t;
        logic [W-1:0] w;
        t = {12{seed ^ 32'h5a5a_1234}};
        w = t[W-1:0];
        w[128]   = disc;
        w[31:24] = port;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]   w;
        logic [W-1:0]   wc;
        logic [127:0]   held_md;

        rst = 1'b1;
        comp_meta_data_in = '0;
        comp_meta_data_valid_in = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_md",    out_md,          128'(0));
        chk("rst_out_port",  128'(out_port),  128'(0));
        chk("rst_drop_cnt",  128'(drop_cnt),  128'(0));
        chk("rst_ovf_cnt",   128'(ovf_cnt),   128'(0));
        chk("rst_fifo_full", 128'(fifo_full), 128'(0));

        // Single forward descriptor, two-cycle latency
        w = mk(1'b0, 8'h04, 32'h1111_0001);
        comp_meta_data_in = w;
        comp_meta_data_valid_in = 1'b1;
        tick();
        comp_meta_data_valid_in = 1'b0;
        chk("lat_cyc1_valid", 128'(out_valid), 128'(0));
        tick();
        chk("lat_cyc2_valid", 128'(out_valid), 128'(1));
        chk("lat_port",       128'(out_port),  128'(8'h04));
        chk("lat_md",         out_md,          w[127:0]);
        chk("lat_drop",       128'(drop_cnt),  128'(0));
        tick();
        chk("lat_done_valid", 128'(out_valid), 128'(0));

        // Discard, port-0, then forward on consecutive cycles
        comp_meta_data_valid_in = 1'b1;
        comp_meta_data_in = mk(1'b1, 8'h05, 32'h2222_0001);
        tick();
        comp_meta_data_in = mk(1'b0, 8'h00, 32'h2222_0002);
        tick();
        wc = mk(1'b0, 8'h10, 32'h2222_0003);
        comp_meta_data_in = wc;
        tick();
        comp_meta_data_valid_in = 1'b0;
        chk("drop_cnt2",     128'(drop_cnt),  128'(2));
        chk("drop_no_out",   128'(out_valid), 128'(0));
        tick();
        chk("drop_fwd_valid", 128'(out_valid), 128'(1));
        chk("drop_fwd_port",  128'(out_port),  128'(8'h10));
        chk("drop_fwd_md",    out_md,          wc[127:0]);
        tick();
        chk("drop_single_out", 128'(out_valid), 128'(0));
        chk("drop_cnt_keep",   128'(drop_cnt),  128'(2));

        // Stalled consumer, six forwards into a four-deep FIFO
        out_ready = 1'b0;
        comp_meta_data_valid_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            w = mk(1'b0, 8'(8'h21 + i), 32'h3333_0000 + 32'(i));
            if (i == 0) held_md = w[127:0];
            comp_meta_data_in = w;
            tick();
            if (i >= 1) begin
                chk("stall_valid", 128'(out_valid), 128'(1));
                chk("stall_port",  128'(out_port),  128'(8'h21));
            end
        end
        comp_meta_data_valid_in = 1'b0;
        chk("stall_full", 128'(fifo_full), 128'(1));
        chk("stall_ovf",  128'(ovf_cnt),   128'(1));
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_hold_port", 128'(out_port), 128'(8'h21));
            chk("stall_hold_md",   out_md,         held_md);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("drain_valid", 128'(out_valid), 128'(1));
            chk("drain_port",  128'(out_port),  128'(8'h21 + k));
            tick();
            if (k == 0) chk("drain_not_full", 128'(fifo_full), 128'(0));
        end
        chk("drain_done",    128'(out_valid), 128'(0));
        chk("drain_ovf_keep", 128'(ovf_cnt),  128'(1));

        // Reset during HOLD with two buffered entries
        out_ready = 1'b0;
        comp_meta_data_valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            comp_meta_data_in = mk(1'b0, 8'(8'h31 + i), 32'h4444_0000 + 32'(i));
            tick();
        end
        comp_meta_data_valid_in = 1'b0;
        chk("pre_rst_valid", 128'(out_valid), 128'(1));
        chk("pre_rst_port",  128'(out_port),  128'(8'h31));
        rst = 1'b1;
        comp_meta_data_valid_in = 1'b1;
        comp_meta_data_in = mk(1'b0, 8'h34, 32'h4444_0009);
        tick();
        rst = 1'b0;
        comp_meta_data_valid_in = 1'b0;
        chk("post_rst_valid", 128'(out_valid), 128'(0));
        chk("post_rst_drop",  128'(drop_cnt),  128'(0));
        chk("post_rst_ovf",   128'(ovf_cnt),   128'(0));
        chk("post_rst_port",  128'(out_port),  128'(0));
        chk("post_rst_md",    out_md,          128'(0));
        chk("post_rst_full",  128'(fifo_full), 128'(0));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("flushed_no_out", 128'(out_valid), 128'(0));
        end

        // Drop counter saturation with a 4-bit counter
        comp_meta_data_valid_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            comp_meta_data_in = mk(1'b1, 8'h07, 32'h5555_0000 + 32'(i));
            tick();
            if (i == 9) chk("sat_mid_drop", 128'(drop_cnt), 128'(9));
        end
        comp_meta_data_valid_in = 1'b0;
        tick();
        tick();
        chk("sat_drop",  128'(drop_cnt),  128'(15));
        chk("sat_ovf",   128'(ovf_cnt),   128'(0));
        chk("sat_valid", 128'(out_valid), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/meta_dispatch.md
META_DISPATCH -- requirements
Module: meta_dispatch

Interface
REQ-001 Parameter META_LEN, default 256, metadata width.
REQ-002 Parameter COMP_LEN, default 100, compare-instruction width carried above the metadata.
REQ-003 Parameter FIFO_DEPTH, default 4, input buffer entries; power of two, at least 2.
REQ-004 Parameter CNT_W, default 32, drop/overflow counter width.
REQ-005 clk  input  1  the single clock; all logic is on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 comp_meta_data_in  input  META_LEN+COMP_LEN  final-stage metadata plus compare instruction.
REQ-008 comp_meta_data_valid_in  input  1  input word valid; no backpressure toward the upstream stage.
REQ-009 out_md  output  128  NetFPGA metadata, bits [127:0] of the input word.
REQ-010 out_port  output  8  destination port, bits [31:24] of the input word.
REQ-011 out_valid / out_ready  output / input  1 / 1  output handshake; a transfer happens when both are high.
REQ-012 drop_cnt  output  CNT_W  count of dropped descriptors.
REQ-013 ovf_cnt  output  CNT_W  count of inputs lost because the FIFO was full.
REQ-014 fifo_full  output  1  FIFO holds FIFO_DEPTH entries.

Function
REQ-015 Each valid input is written to the FIFO tail in its arrival cycle, unless the FIFO is full.
REQ-016 When the FIFO is full at arrival, the input is discarded and ovf_cnt increments; no entry is overwritten.
REQ-017 An entry is a drop entry when discard bit [128] is 1 or out_port bits [31:24] are 0.
REQ-018 FSM states: IDLE (FIFO empty, output register empty), EVAL (head present, output register empty), HOLD (out_valid high).
REQ-019 In EVAL, a drop-entry head is popped and drop_cnt increments; at most one pop per cycle.
REQ-020 In EVAL, a forward-entry head is popped and loaded into the output register; out_valid rises the next cycle (HOLD).
REQ-021 In HOLD with out_ready high: the transfer completes; if a forward-entry head exists, it loads in the same cycle and out_valid stays high (back-to-back); otherwise go to EVAL or IDLE.
REQ-022 In HOLD with out_ready low, out_md and out_port stay stable and out_valid stays high.
REQ-023 Latency from input to out_valid on an empty block is 2 cycles: one cycle write, one cycle evaluate and load.
REQ-024 A simultaneous push and pop on a full FIFO is a push to a full FIFO: the input is overflowed and the pop proceeds.
REQ-025 A simultaneous push and pop on a non-full FIFO both occur; occupancy is unchanged.
REQ-026 A push into an empty FIFO is not visible to EVAL until the next cycle.
REQ-027 drop_cnt and ovf_cnt saturate at all-ones and do not wrap.
REQ-028 Read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full and empty are decoded from the MSB.
REQ-029 Bits [355:256] (compare instruction) and [255:250] (next_table_id) are ignored.

Reset
REQ-030 On rst high at a clock edge: FIFO emptied, FSM goes to IDLE, out_valid=0, out_md=0, out_port=0, drop_cnt=0, ovf_cnt=0, fifo_full=0.
REQ-031 Reset asserted during HOLD drops the held descriptor without a transfer; inputs during reset are ignored and not counted.

Structure
REQ-032 The field offsets (DISCARD_BIT=128, PORT_HI=31, PORT_LO=24, NTID_HI=255, NTID_LO=250) and the FSM state enum live in the shared RMT metadata package, which alu_3 also uses.
REQ-033 The FIFO is a sub-module, meta_fifo (synchronous, registered pointers, combinational head read); the FSM and counters live in meta_dispatch.

Verification
REQ-034 One input with port 0x04 and discard 0, out_ready held 1 -> out_valid at cycle +2, out_port=0x04, out_md equal to input [127:0], drop_cnt=0.
REQ-035 Three inputs on consecutive cycles: discard=1; port=0x00; port=0x10 -> drop_cnt=2, a single output with out_port=0x10.
REQ-036 out_ready=0 and six forward inputs back-to-back (FIFO_DEPTH=4) -> fifo_full=1, ovf_cnt=1 (one held in the output register, four buffered, one lost), out_port stable throughout; then out_ready=1 -> five transfers on consecutive cycles.
REQ-037 drop_cnt preloaded near all-ones via CNT_W=4, then 20 discard inputs -> drop_cnt=15, no wrap.
REQ-038 rst pulsed for one cycle during HOLD with two entries buffered -> next cycle out_valid=0, counters 0, and no later output for the flushed entries.
